// File: rtl/video_in_pack.sv
// rtl/video_in_pack.sv - camera stream capture, 4-pixel packer and line/frame timing checks
module video_in_pack #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        enable,
  input  logic [7:0]  pixel_in,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic        fifo_full,
  input  logic        clr_ovf,
  output logic        w_req,
  output logic [31:0] w_data,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic        line_err,
  output logic        overflow,
  output logic [9:0]  line_cnt
);

  typedef enum logic [1:0] {SYNC, ARMED, FRAME} state_t;

  localparam logic [10:0] WIDTH_L  = 11'(WIDTH);
  localparam logic [9:0]  HEIGHT_L = 10'(HEIGHT);

  state_t      state;
  logic        fv_d, lv_d;
  logic [10:0] pix_cnt;
  logic [1:0]  slot;
  logic [23:0] pack;

  logic        fv_rise, fv_fall, lv_rise, lv_fall;
  logic        in_frame, pix_ok, line_end;
  logic [1:0]  cur_slot;
  logic [10:0] cnt_base, pix_next;
  logic [9:0]  line_inc, lines_final;

  always_comb begin
    fv_rise     = frame_valid & ~fv_d;
    fv_fall     = ~frame_valid & fv_d;
    lv_rise     = line_valid & ~lv_d;
    lv_fall     = ~line_valid & lv_d;
    in_frame    = (state == FRAME);
    pix_ok      = in_frame & frame_valid & line_valid;
    cur_slot    = lv_rise ? 2'd0 : slot;
    cnt_base    = lv_rise ? 11'd0 : pix_cnt;
    pix_next    = (cnt_base == 11'h7FF) ? cnt_base : cnt_base + 11'd1;
    // A frame ending with line_valid still high closes that line in the same clk.
    line_end    = in_frame & (lv_fall | (fv_fall & line_valid));
    line_inc    = (line_cnt == 10'h3FF) ? line_cnt : line_cnt + 10'd1;
    lines_final = line_end ? line_inc : line_cnt;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= SYNC;
      fv_d       <= 1'b0;
      lv_d       <= 1'b0;
      pix_cnt    <= '0;
      slot       <= '0;
      pack       <= '0;
      w_req      <= 1'b0;
      w_data     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      line_err   <= 1'b0;
      overflow   <= 1'b0;
      line_cnt   <= '0;
    end else begin
      fv_d       <= frame_valid;
      lv_d       <= line_valid;
      w_req      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      line_err   <= 1'b0;

      if (clr_ovf)
        overflow <= 1'b0;

      if (pix_ok) begin
        pix_cnt <= pix_next;
        slot    <= cur_slot + 2'd1;
        case (cur_slot)
          2'd0:    pack[7:0]   <= pixel_in;
          2'd1:    pack[15:8]  <= pixel_in;
          2'd2:    pack[23:16] <= pixel_in;
          default: begin
            // A full FIFO drops the word but keeps the slot sequence aligned.
            if (fifo_full) begin
              overflow <= 1'b1;
            end else begin
              w_req  <= 1'b1;
              w_data <= {pixel_in, pack};
            end
          end
        endcase
      end else if (lv_rise) begin
        pix_cnt <= '0;
        slot    <= '0;
      end

      if (line_end) begin
        line_cnt <= line_inc;
        line_err <= (pix_cnt != WIDTH_L);
      end

      case (state)
        SYNC: begin
          if (!frame_valid)
            state <= ARMED;
        end
        ARMED: begin
          if (fv_rise && enable) begin
            state    <= FRAME;
            busy     <= 1'b1;
            line_cnt <= '0;
          end
        end
        FRAME: begin
          if (fv_fall) begin
            state      <= ARMED;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_err  <= (lines_final != HEIGHT_L);
          end
        end
        default: begin
          state <= SYNC;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_in_pack.sv
// tb/tb_video_in_pack.sv - table-driven frame vectors with a word scoreboard for video_in_pack
module tb_video_in_pack;
  localparam int W = 8;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        nRST, enable, frame_valid, line_valid, fifo_full, clr_ovf;
  logic [7:0]  pixel_in;
  logic        w_req, busy, frame_done, frame_err, line_err, overflow;
  logic [31:0] w_data;
  logic [9:0]  line_cnt;

  always #5 clk = ~clk;

  video_in_pack #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .nRST(nRST), .enable(enable), .pixel_in(pixel_in),
    .frame_valid(frame_valid), .line_valid(line_valid), .fifo_full(fifo_full),
    .clr_ovf(clr_ovf), .w_req(w_req), .w_data(w_data), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .line_err(line_err),
    .overflow(overflow), .line_cnt(line_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int n_done = 0, n_ferr = 0, n_lerr = 0, n_alone = 0;

  always @(negedge clk) begin
    if (w_req) got_q.push_back(w_data);
    if (frame_done) n_done++;
    if (frame_err) n_ferr++;
    if (frame_err && !frame_done) n_alone++;
    if (line_err) n_lerr++;
  end

  typedef struct {
    bit en;
    int lines;
    int npix;
    int full_grp;
    int exp_lerr;
    int exp_done;
    int exp_ferr;
    int exp_ovf;
    int exp_lcnt;
  } row_t;

  row_t rows[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    chk({name, "_words"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({name, "_word"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_row(input int i);
    row_t r;
    int d0, f0, l0;
    logic [7:0] pv;
    logic [31:0] w;
    r  = rows[i];
    d0 = n_done;
    f0 = n_ferr;
    l0 = n_lerr;
    pv = 8'h00;
    w  = '0;
    enable = r.en;
    frame_valid = 1'b1;
    cyc();
    cyc();
    chk($sformatf("busy_row%0d", i), 32'(busy), 32'(r.en));
    for (int l = 0; l < r.lines; l++) begin
      for (int p = 0; p < r.npix; p++) begin
        pixel_in   = pv;
        line_valid = 1'b1;
        fifo_full  = (l == 0 && p / 4 == r.full_grp);
        w[8*(p%4) +: 8] = pv;
        if (p % 4 == 3 && r.en && !fifo_full) exp_q.push_back(w);
        pv++;
        cyc();
      end
      line_valid = 1'b0;
      fifo_full  = 1'b0;
      cyc();
      cyc();
    end
    frame_valid = 1'b0;
    cyc();
    cyc();
    drain($sformatf("row%0d", i));
    chk($sformatf("frame_done_row%0d", i), 32'(n_done - d0), 32'(r.exp_done));
    chk($sformatf("frame_err_row%0d", i), 32'(n_ferr - f0), 32'(r.exp_ferr));
    chk($sformatf("line_err_row%0d", i), 32'(n_lerr - l0), 32'(r.exp_lerr));
    chk($sformatf("overflow_row%0d", i), 32'(overflow), 32'(r.exp_ovf));
    chk($sformatf("line_cnt_row%0d", i), 32'(line_cnt), 32'(r.exp_lcnt));
    chk($sformatf("busy_idle_row%0d", i), 32'(busy), 32'd0);
  endtask

  initial begin
    //          en lines npix full lerr done ferr ovf lcnt
    rows[0] = '{1, 2, 8, -1, 0, 1, 0, 0, 2};
    rows[1] = '{1, 1, 6, -1, 1, 1, 1, 0, 1};
    rows[2] = '{1, 2, 8,  1, 0, 1, 0, 1, 2};
    rows[3] = '{1, 3, 8, -1, 0, 1, 1, 0, 3};
    rows[4] = '{0, 2, 8, -1, 0, 0, 0, 0, 3};

    nRST = 1'b0; enable = 1'b1; frame_valid = 1'b1; line_valid = 1'b0;
    fifo_full = 1'b0; clr_ovf = 1'b0; pixel_in = 8'h00;
    cyc();
    cyc();
    chk("reset_w_req", 32'(w_req), 32'd0);
    chk("reset_w_data", w_data, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_line_cnt", 32'(line_cnt), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Release mid-frame: a full line must not be captured.
    nRST = 1'b1;
    cyc();
    for (int p = 0; p < W; p++) begin
      line_valid = 1'b1;
      pixel_in   = 8'(p + 8'h40);
      cyc();
    end
    line_valid = 1'b0;
    cyc();
    chk("midframe_words", 32'(got_q.size()), 32'd0);
    chk("midframe_busy", 32'(busy), 32'd0);
    frame_valid = 1'b0;
    cyc();
    cyc();

    for (int i = 0; i < 4; i++) begin
      run_row(i);
      if (i == 2) begin
        cyc();
        chk("overflow_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("overflow_cleared", 32'(overflow), 32'd0);
      end
    end
    run_row(4);
    chk("ferr_without_done", 32'(n_alone), 32'd0);

    // Reset mid-line after two pixels, then resync through a clean frame.
    enable = 1'b1;
    frame_valid = 1'b1;
    cyc();
    cyc();
    line_valid = 1'b1;
    pixel_in = 8'hA0;
    cyc();
    pixel_in = 8'hA1;
    cyc();
    nRST = 1'b0;
    #1;
    chk("midline_rst_w_req", 32'(w_req), 32'd0);
    chk("midline_rst_busy", 32'(busy), 32'd0);
    chk("midline_rst_line_cnt", 32'(line_cnt), 32'd0);
    cyc();
    nRST = 1'b1;
    for (int p = 0; p < 6; p++) begin
      pixel_in = 8'(8'hA2 + p);
      cyc();
    end
    line_valid = 1'b0;
    cyc();
    frame_valid = 1'b0;
    cyc();
    cyc();
    chk("post_rst_words", 32'(got_q.size()), 32'd0);
    run_row(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
